// File: rtl/decode_stage_if.sv
// ID/EX pipeline bus: decoded instruction plus operands handed to the execute stage.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [3:0]        exe_cmd;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en_out;
  logic              s_out;
  logic              b_out;
  logic              imm_out;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm24;
  logic [3:0]        dest;
  logic [3:0]        src1_out;
  logic [3:0]        src2_out;
  logic              valid_out;

  modport master (
    output pc_out, val_rn, val_rm, exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out,
           b_out, imm_out, shift_operand, signed_imm24, dest, src1_out, src2_out, valid_out
  );

  modport slave (
    input  pc_out, val_rn, val_rm, exe_cmd, mem_r_en, mem_w_en, wb_en_out, s_out,
           b_out, imm_out, shift_operand, signed_imm24, dest, src1_out, src2_out, valid_out
  );
endinterface

// File: rtl/decode_stage.sv
// ARM decode stage: register file, condition check, control decode, hazard
// detection and the ID/EX register with flush/freeze/bubble handling.
module decode_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FWD_EN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        status_in,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic              exe_mem_r_en,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  output logic              hazard,
  decode_stage_if.master    id_ex
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [3:0]        exe_cmd;
    logic              mem_r;
    logic              mem_w;
    logic              wb;
    logic              s;
    logic              b;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              valid;
  } idex_t;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  idex_t             idex_q;
  idex_t             idex_d;

  logic [3:0] cond, opcode, rn, rd, rm, src2;
  logic [1:0] mode;
  logic       i_bit, s_bit, is_store, two_src, cond_ok, nop;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [3:0] exe_cmd;
  logic       mem_r, mem_w, wb, s, b, imm;

  assign cond     = instr_in[31:28];
  assign mode     = instr_in[27:26];
  assign i_bit    = instr_in[25];
  assign opcode   = instr_in[24:21];
  assign s_bit    = instr_in[20];
  assign rn       = instr_in[19:16];
  assign rd       = instr_in[15:12];
  assign rm       = instr_in[3:0];
  assign is_store = (mode == 2'b01) && !s_bit;
  assign src2     = is_store ? rd : rm;
  assign two_src  = !i_bit || is_store;
  assign {flag_n, flag_z, flag_c, flag_v} = status_in;

  // Next register-file contents; reads use it too, giving write-through.
  always_comb begin
    rf_d = rf_q;
    if (wb_en && (32'(wb_dest) < NUM_REGS)) begin
      rf_d[IDX_W'(wb_dest)] = wb_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] idx,
                                                 input logic [DATA_W-1:0] regs [NUM_REGS]);
    if (32'(idx) < NUM_REGS) begin
      read_reg = regs[IDX_W'(idx)];
    end else begin
      read_reg = '0;
    end
  endfunction

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    exe_cmd = 4'b0000;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    wb      = 1'b0;
    s       = 1'b0;
    b       = 1'b0;
    imm     = i_bit;
    nop     = 1'b0;
    case (mode)
      2'b00: begin
        s  = s_bit;
        wb = 1'b1;
        case (opcode)
          4'b1101: exe_cmd = 4'b0001;
          4'b1111: exe_cmd = 4'b1001;
          4'b0100: exe_cmd = 4'b0010;
          4'b0101: exe_cmd = 4'b0011;
          4'b0010: exe_cmd = 4'b0100;
          4'b0110: exe_cmd = 4'b0101;
          4'b0000: exe_cmd = 4'b0110;
          4'b1100: exe_cmd = 4'b0111;
          4'b0001: exe_cmd = 4'b1000;
          4'b1010: begin exe_cmd = 4'b0100; wb = 1'b0; s = 1'b1; end
          4'b1000: begin exe_cmd = 4'b0110; wb = 1'b0; s = 1'b1; end
          default: nop = 1'b1;
        endcase
      end
      2'b01: begin
        exe_cmd = 4'b0010;
        s       = s_bit;
        mem_r   = s_bit;
        wb      = s_bit;
        mem_w   = !s_bit;
      end
      2'b10: begin
        b   = 1'b1;
        imm = 1'b1;
      end
      default: nop = 1'b1;
    endcase
    if (nop) begin
      exe_cmd = 4'b0000;
      imm     = 1'b0;
    end
    if (nop || !cond_ok) begin
      wb    = 1'b0;
      mem_r = 1'b0;
      mem_w = 1'b0;
      b     = 1'b0;
      s     = 1'b0;
    end
  end

  // With forwarding only a load in EX forces a stall; branches read nothing.
  always_comb begin
    hazard = 1'b0;
    if (mode != 2'b10) begin
      if (FWD_EN != 0) begin
        hazard = exe_mem_r_en && exe_wb_en &&
                 ((exe_dest == rn) || (two_src && (exe_dest == src2)));
      end else begin
        hazard = (exe_wb_en && (exe_dest == rn)) || (mem_wb_en && (mem_dest == rn)) ||
                 (two_src && ((exe_wb_en && (exe_dest == src2)) ||
                              (mem_wb_en && (mem_dest == src2))));
      end
    end
  end

  always_comb begin
    idex_d               = '0;
    idex_d.pc            = pc_in;
    idex_d.val_rn        = read_reg(rn, rf_d);
    idex_d.val_rm        = read_reg(src2, rf_d);
    idex_d.exe_cmd       = exe_cmd;
    idex_d.mem_r         = mem_r;
    idex_d.mem_w         = mem_w;
    idex_d.wb            = wb;
    idex_d.s             = s;
    idex_d.b             = b;
    idex_d.imm           = imm;
    idex_d.shift_operand = instr_in[11:0];
    idex_d.signed_imm24  = instr_in[23:0];
    idex_d.dest          = rd;
    idex_d.src1          = rn;
    idex_d.src2          = src2;
    idex_d.valid         = 1'b1;
    if (flush) begin
      idex_d = '0;
    end else if (freeze) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign id_ex.pc_out        = idex_q.pc;
  assign id_ex.val_rn        = idex_q.val_rn;
  assign id_ex.val_rm        = idex_q.val_rm;
  assign id_ex.exe_cmd       = idex_q.exe_cmd;
  assign id_ex.mem_r_en      = idex_q.mem_r;
  assign id_ex.mem_w_en      = idex_q.mem_w;
  assign id_ex.wb_en_out     = idex_q.wb;
  assign id_ex.s_out         = idex_q.s;
  assign id_ex.b_out         = idex_q.b;
  assign id_ex.imm_out       = idex_q.imm;
  assign id_ex.shift_operand = idex_q.shift_operand;
  assign id_ex.signed_imm24  = idex_q.signed_imm24;
  assign id_ex.dest          = idex_q.dest;
  assign id_ex.src1_out      = idex_q.src1;
  assign id_ex.src2_out      = idex_q.src2;
  assign id_ex.valid_out     = idex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: one instance per hazard mode, shared stimulus.
module tb_decode_stage;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] I_ADD  = 32'hE083_1003;
  localparam logic [31:0] I_MOV  = 32'hE1A0_0002;
  localparam logic [31:0] I_ADNE = 32'h1081_1002;
  localparam logic [31:0] I_STR  = 32'hE585_4000;
  localparam logic [31:0] I_ADDI = 32'hE282_1004;
  localparam logic [31:0] I_B    = 32'hEA00_0010;
  localparam logic [31:0] I_LDR  = 32'hE595_6000;
  localparam logic [31:0] I_CMP  = 32'hE153_0003;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        wb;
    logic        s;
    logic        mr;
    logic        mw;
    logic        b;
    logic        imm;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
  } out_t;

  typedef struct packed {
    logic [31:0] id;
    out_t        e0;
    out_t        e1;
    logic        h0;
    logic        h1;
  } item_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] pc_in;
  logic [31:0]       instr_in;
  logic              freeze, flush;
  logic [3:0]        status_in;
  logic              wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic [3:0]        exe_dest, mem_dest;
  logic              hazard0, hazard1;

  int    errors = 0;
  int    checks = 0;
  int    n_items = 0;
  item_t sb[$];
  item_t pend;
  bit    have_pend = 1'b0;
  out_t  act0, act1;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DATA_W)) bus0 ();
  decode_stage_if #(.DATA_W(DATA_W)) bus1 ();

  decode_stage #(.DATA_W(DATA_W), .NUM_REGS(16), .FWD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .freeze(freeze), .flush(flush),
    .status_in(status_in), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard0), .id_ex(bus0)
  );

  decode_stage #(.DATA_W(DATA_W), .NUM_REGS(16), .FWD_EN(1)) dut1 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .freeze(freeze), .flush(flush),
    .status_in(status_in), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard1), .id_ex(bus1)
  );

  assign act0 = {bus0.valid_out, bus0.exe_cmd, bus0.wb_en_out, bus0.s_out, bus0.mem_r_en,
                 bus0.mem_w_en, bus0.b_out, bus0.imm_out, bus0.pc_out, bus0.val_rn,
                 bus0.val_rm, bus0.dest};
  assign act1 = {bus1.valid_out, bus1.exe_cmd, bus1.wb_en_out, bus1.s_out, bus1.mem_r_en,
                 bus1.mem_w_en, bus1.b_out, bus1.imm_out, bus1.pc_out, bus1.val_rn,
                 bus1.val_rm, bus1.dest};

  function automatic out_t mk(input logic v, input logic [3:0] cmd, input logic wb,
                              input logic s, input logic mr, input logic mw, input logic b,
                              input logic imm, input logic [31:0] pc, input logic [31:0] rn,
                              input logic [31:0] rm, input logic [3:0] d);
    mk = {v, cmd, wb, s, mr, mw, b, imm, pc, rn, rm, d};
  endfunction

  task automatic check_out(input string name, input logic [31:0] id, input out_t act,
                           input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s item %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic [31:0] id, input logic act,
                           input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s item %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // Hazard is checked in the issue cycle; registered outputs one cycle later.
  always @(negedge clk) begin
    if (have_pend) begin
      check_out("out_fwd0", pend.id, act0, pend.e0);
      check_out("out_fwd1", pend.id, act1, pend.e1);
      have_pend = 1'b0;
    end
    if (sb.size() != 0) begin
      pend = sb.pop_front();
      have_pend = 1'b1;
      check_bit("hazard_fwd0", pend.id, hazard0, pend.h0);
      check_bit("hazard_fwd1", pend.id, hazard1, pend.h1);
    end
  end

  task automatic issue(input out_t e0, input out_t e1, input logic h0, input logic h1);
    item_t it;
    it.id = 32'(n_items);
    it.e0 = e0;
    it.e1 = e1;
    it.h0 = h0;
    it.h1 = h1;
    n_items++;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic ewb, input logic [3:0] ed, input logic emr,
                         input logic mwb, input logic [3:0] md);
    exe_wb_en    = ewb;
    exe_dest     = ed;
    exe_mem_r_en = emr;
    mem_wb_en    = mwb;
    mem_dest     = md;
  endtask

  initial begin
    out_t bub, o_add, o_cmp;
    bub = '0;
    rst = 1'b1;
    pc_in = '0; instr_in = '0; freeze = 1'b0; flush = 1'b0; status_in = 4'b0000;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    set_fwd(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds outputs at zero even with an instruction present.
    pc_in = 32'h10; instr_in = I_ADD;
    issue(bub, bub, 1'b0, 1'b0);
    issue(bub, bub, 1'b0, 1'b0);

    // Release reset; write R3 while decoding a condition-failed AND R0,R0,R0.
    rst = 1'b1; pc_in = 32'h14; instr_in = 32'h0;
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hAA;
    issue(mk(1, 4'b0110, 0, 0, 0, 0, 0, 0, 32'h14, 0, 0, 4'd0),
          mk(1, 4'b0110, 0, 0, 0, 0, 0, 0, 32'h14, 0, 0, 4'd0), 1'b0, 1'b0);

    wb_en = 1'b0; pc_in = 32'h18; instr_in = I_ADD;
    o_add = mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h18, 32'hAA, 32'hAA, 4'd1);
    issue(o_add, o_add, 1'b0, 1'b0);

    // Write-through of R2 into a MOV in the same cycle.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55; pc_in = 32'h1C; instr_in = I_MOV;
    issue(mk(1, 4'b0001, 1, 0, 0, 0, 0, 0, 32'h1C, 0, 32'h55, 4'd0),
          mk(1, 4'b0001, 1, 0, 0, 0, 0, 0, 32'h1C, 0, 32'h55, 4'd0), 1'b0, 1'b0);

    wb_en = 1'b0; status_in = 4'b0100; pc_in = 32'h20; instr_in = I_ADNE;
    issue(mk(1, 4'b0010, 0, 0, 0, 0, 0, 0, 32'h20, 0, 32'h55, 4'd1),
          mk(1, 4'b0010, 0, 0, 0, 0, 0, 0, 32'h20, 0, 32'h55, 4'd1), 1'b0, 1'b0);
    status_in = 4'b0000;
    issue(mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h20, 0, 32'h55, 4'd1),
          mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h20, 0, 32'h55, 4'd1), 1'b0, 1'b0);

    // RAW on R3 in EX: non-load stalls only without forwarding.
    set_fwd(1'b1, 4'd3, 1'b0, 1'b0, 4'd0); pc_in = 32'h24; instr_in = I_ADD;
    issue(bub, mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h24, 32'hAA, 32'hAA, 4'd1), 1'b1, 1'b0);
    set_fwd(1'b1, 4'd3, 1'b1, 1'b0, 4'd0); pc_in = 32'h28;
    issue(bub, bub, 1'b1, 1'b1);

    // Store data register Rd is a source.
    set_fwd(1'b1, 4'd4, 1'b0, 1'b0, 4'd0); pc_in = 32'h2C; instr_in = I_STR;
    issue(bub, mk(1, 4'b0010, 0, 0, 0, 1, 0, 0, 32'h2C, 0, 0, 4'd4), 1'b1, 1'b0);
    set_fwd(1'b1, 4'd4, 1'b1, 1'b0, 4'd0);
    issue(bub, bub, 1'b1, 1'b1);

    // Immediate form does not read Rm.
    pc_in = 32'h30; instr_in = I_ADDI;
    issue(mk(1, 4'b0010, 1, 0, 0, 0, 0, 1, 32'h30, 32'h55, 0, 4'd1),
          mk(1, 4'b0010, 1, 0, 0, 0, 0, 1, 32'h30, 32'h55, 0, 4'd1), 1'b0, 1'b0);

    // RAW against MEM stage.
    set_fwd(1'b0, 4'd0, 1'b0, 1'b1, 4'd3); pc_in = 32'h34; instr_in = I_ADD;
    issue(bub, mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h34, 32'hAA, 32'hAA, 4'd1), 1'b1, 1'b0);

    // Branch never stalls even with matching load in EX.
    set_fwd(1'b1, 4'd0, 1'b1, 1'b1, 4'd0); pc_in = 32'h38; instr_in = I_B;
    issue(mk(1, 4'b0000, 0, 0, 0, 0, 1, 1, 32'h38, 0, 0, 4'd0),
          mk(1, 4'b0000, 0, 0, 0, 0, 1, 1, 32'h38, 0, 0, 4'd0), 1'b0, 1'b0);

    set_fwd(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); pc_in = 32'h3C; instr_in = I_LDR;
    issue(mk(1, 4'b0010, 1, 1, 1, 0, 0, 0, 32'h3C, 0, 0, 4'd6),
          mk(1, 4'b0010, 1, 1, 1, 0, 0, 0, 32'h3C, 0, 0, 4'd6), 1'b0, 1'b0);

    pc_in = 32'h40; instr_in = I_CMP;
    o_cmp = mk(1, 4'b0100, 0, 1, 0, 0, 0, 0, 32'h40, 32'hAA, 32'hAA, 4'd0);
    issue(o_cmp, o_cmp, 1'b0, 1'b0);

    // Freeze holds for three cycles, including while a hazard is raised.
    freeze = 1'b1; pc_in = 32'h44; instr_in = I_ADD;
    issue(o_cmp, o_cmp, 1'b0, 1'b0);
    set_fwd(1'b1, 4'd3, 1'b0, 1'b0, 4'd0); pc_in = 32'h48;
    issue(o_cmp, o_cmp, 1'b1, 1'b0);
    set_fwd(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); pc_in = 32'h4C;
    issue(o_cmp, o_cmp, 1'b0, 1'b0);

    flush = 1'b1; pc_in = 32'h50;
    issue(bub, bub, 1'b0, 1'b0);

    freeze = 1'b0; flush = 1'b0; pc_in = 32'h54;
    o_add = mk(1, 4'b0010, 1, 0, 0, 0, 0, 0, 32'h54, 32'hAA, 32'hAA, 4'd1);
    issue(o_add, o_add, 1'b0, 1'b0);

    flush = 1'b1; pc_in = 32'h58; instr_in = I_MOV;
    issue(bub, bub, 1'b0, 1'b0);
    flush = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || have_pend) begin
      errors++;
      $display("FAIL drain: got %0d items left expected 0", sb.size() + int'(have_pend));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised ARM instruction-decode stage with its ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It combines the register file, condition check, control decode, hazard detection and bubble/freeze/flush handling in one block. Unlike the earlier decode block, it registers its outputs, produces the hazard stall itself, and supports a forwarding-aware hazard mode.

## Interface
- DATA_W, 32, datapath and register width
- NUM_REGS, 16, implemented registers (2..16); index ≥ NUM_REGS reads 0, writes ignored
- FWD_EN, 0, 0: stall on any RAW match; 1: stall only on load-use
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- pc_in  in  DATA_W  PC+4 from IF/ID
- instr_in  in  32  instruction from IF/ID
- freeze  in  1  hold ID/EX register unchanged
- flush  in  1  branch taken: load bubble
- status_in  in  4  {N,Z,C,V} from status register
- wb_en, wb_dest[3:0], wb_value[DATA_W]  in  write-back port
- exe_wb_en, exe_dest[3:0], exe_mem_r_en  in  EX-stage destination info
- mem_wb_en, mem_dest[3:0]  in  MEM-stage destination info
- hazard  out  1  combinational stall request to IF and IF/ID
- pc_out, val_rn, val_rm  out  DATA_W  registered
- exe_cmd  out  4, registered
- mem_r_en, mem_w_en, wb_en_out, s_out, b_out, imm_out  out  1  registered
- shift_operand  out  12; signed_imm24  out  24; dest, src1_out, src2_out  out  4  registered
- valid_out  out  1  registered, 0 for bubbles

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
- Source 1 is Rn. Source 2 is Rd when the instruction is a store (mode 01, S=0), else Rm.
- two_src = ~I | store.
- Condition (cond, flags) maps as follows:
  - EQ Z, NE ~Z, CS C, CC ~C
  - MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 0
- Control decode, mode 00 (opcode→exe_cmd):
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - All of the above set wb=1.
  - CMP 1010→0100 and TST 1000→0110 set wb=0 and force s=1.
- Control decode, mode 01: exe_cmd 0010.
  - S=1 is LDR: mem_r=1, wb=1.
  - S=0 is STR: mem_w=1.
- Control decode, mode 10: b=1, imm=1.
- Any other mode/opcode decodes as NOP: all enables 0, valid still 1.
- A failed condition or NOP zeroes wb, mem_r, mem_w, b and s.
- hazard with FWD_EN=0:
  - (exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1)
  - plus the same two terms on src2, gated by two_src
- hazard with FWD_EN=1: exe_mem_r_en & exe_wb_en & exe_dest matches src1, or src2 when two_src.
- Branches (mode 10) never raise hazard.
- Register file:
  - NUM_REGS×DATA_W, asynchronous read.
  - Write on rising edge when wb_en.
  - Write-through: reading wb_dest while wb_en returns wb_value in the same cycle.
- ID/EX load priority, per rising edge:
  1. flush: bubble
  2. freeze: hold
  3. hazard: bubble
  4. otherwise: load the decoded values
- Bubble = all control/enable bits 0, valid_out 0, data fields 0.

## Timing
- rst low clears, asynchronously:
  - all registered outputs to 0
  - all registers to 0
- Latency: decoded instruction appears on outputs one cycle after it is on instr_in.
- hazard is combinational, same cycle as instr_in; no internal state.
- flush together with freeze: flush wins.
- hazard together with freeze: hold; hazard output is still asserted.
- WB write to a register being read in the same cycle: the new value is captured in ID/EX.
- Reset released mid-stream: the first edge after release loads normally.

## Test plan
- Reset + regfile:
  - Stimulus: rst=0, then release; write R3=0x0000_00AA; decode ADD R1,R3,R3 (0xE083_1003).
  - Required: val_rn=val_rm=0xAA, exe_cmd=0010, wb_en_out=1, valid_out=1 one cycle later.
- Write-through:
  - Stimulus: wb_en=1, wb_dest=2, wb_value=0x55 in the same cycle as decoding 0xE1A0_0002 (MOV R0,R2).
  - Required: val_rm=0x55, exe_cmd=0001.
- Condition:
  - Stimulus: status_in=0100 (Z=1); decode ADDNE 0x1081_1002.
  - Required: wb_en_out=0, s_out=0.
  - Same instruction with status_in=0000: wb_en_out=1.
- Hazard FWD_EN=0 vs 1:
  - Stimulus: exe_wb_en=1, exe_dest=3, exe_mem_r_en=0; decode ADD using R3.
  - Required: hazard=1 and bubble (valid_out=0) with FWD_EN=0; hazard=0 with FWD_EN=1.
  - With exe_mem_r_en=1, both modes give hazard=1.
- Store src2:
  - Stimulus: STR R4,[R5] (0xE585_4000) with exe_dest=4, exe_wb_en=1.
  - Required: hazard=1. With an immediate ADD (I=1) reading Rm=4: hazard=0.
- Flush/freeze:
  - freeze=1 holds all outputs for 3 cycles.
  - flush=1 together with freeze=1 gives valid_out=0 and all enables 0 on the next edge.
